// File: rtl/epd_multi_filter.sv
// Ethernet packet detector: preamble/SFD, DST filter, SRC, type/length and size checks, frame counters.
// Optional FCS check compiled in with `define EPD_FCS_CHECK_EN (adds crc_ok output).
module epd_multi_filter #(
  parameter int unsigned PRE_LEN = 7,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             control,
  input  logic [47:0]      my_addr,
  input  logic             promisc,
  output logic             preamble_valid,
  output logic             dst_addr_valid,
  output logic             src_addr_valid,
  output logic             type_length_valid,
  output logic             packet_size_valid,
  output logic             frame_done,
`ifdef EPD_FCS_CHECK_EN
  output logic             crc_ok,
`endif
  output logic [CNT_W-1:0] valid_packet_counter,
  output logic [CNT_W-1:0] error_packet_counter
);

  localparam int unsigned PC_W = $clog2(PRE_LEN + 1);

  typedef enum logic [2:0] {
    WAIT_GAP, IDLE, PRE, DST, SRC, TL, PAYLOAD, DROP
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [2:0]        fld_q, fld_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              cnt_en_q, cnt_en_d;
  logic [39:0]       shift_q, shift_d;
  logic              src_zero_q, src_zero_d, src_ones_q, src_ones_d;
  logic              pv_q, pv_d, dv_q, dv_d, sv_q, sv_d, tv_q, tv_d, szv_q, szv_d;
  logic              fd_q, fd_d;
  logic [CNT_W-1:0]  vpc_q, vpc_d, epc_q, epc_d;
  logic              frame_end, size_ok, good;
  logic [15:0]       tl_val;

`ifdef EPD_FCS_CHECK_EN
  logic [31:0]       crc_q, crc_d;
  logic              crc_ok_q, crc_ok_d;

  // Reflected CRC-32 (poly 0xEDB88320), one byte per clock.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= WAIT_GAP;
      pre_cnt_q  <= '0;
      fld_q      <= '0;
      len_q      <= '0;
      cnt_en_q   <= 1'b0;
      shift_q    <= '0;
      src_zero_q <= 1'b0;
      src_ones_q <= 1'b0;
      pv_q       <= 1'b0;
      dv_q       <= 1'b0;
      sv_q       <= 1'b0;
      tv_q       <= 1'b0;
      szv_q      <= 1'b0;
      fd_q       <= 1'b0;
      vpc_q      <= '0;
      epc_q      <= '0;
`ifdef EPD_FCS_CHECK_EN
      crc_q      <= '1;
      crc_ok_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      fld_q      <= fld_d;
      len_q      <= len_d;
      cnt_en_q   <= cnt_en_d;
      shift_q    <= shift_d;
      src_zero_q <= src_zero_d;
      src_ones_q <= src_ones_d;
      pv_q       <= pv_d;
      dv_q       <= dv_d;
      sv_q       <= sv_d;
      tv_q       <= tv_d;
      szv_q      <= szv_d;
      fd_q       <= fd_d;
      vpc_q      <= vpc_d;
      epc_q      <= epc_d;
`ifdef EPD_FCS_CHECK_EN
      crc_q      <= crc_d;
      crc_ok_q   <= crc_ok_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    fld_d      = fld_q;
    len_d      = len_q;
    cnt_en_d   = cnt_en_q;
    shift_d    = shift_q;
    src_zero_d = src_zero_q;
    src_ones_d = src_ones_q;
    pv_d       = pv_q;
    dv_d       = dv_q;
    sv_d       = sv_q;
    tv_d       = tv_q;
    szv_d      = szv_q;
    fd_d       = 1'b0;
    vpc_d      = vpc_q;
    epc_d      = epc_q;
    tl_val     = {shift_q[7:0], data};
    size_ok    = (len_q >= LEN_W'(MIN_LEN)) && (len_q <= LEN_W'(MAX_LEN));
    good       = pv_q && dv_q && sv_q && tv_q && size_ok;
    frame_end  = !control && (state_q != WAIT_GAP) && (state_q != IDLE);
`ifdef EPD_FCS_CHECK_EN
    crc_d      = crc_q;
    crc_ok_d   = crc_ok_q;
    // Residue 0xC704DD7B in bit-reversed (register) order.
    good       = good && (crc_q == 32'hDEBB20E3);
`endif

    // Size counter and CRC run from the first DST byte, even after a field mismatch.
    if (control && cnt_en_q) begin
      if (len_q != LEN_W'(MAX_LEN + 1)) len_d = len_q + LEN_W'(1);
`ifdef EPD_FCS_CHECK_EN
      crc_d = crc32_byte(crc_q, data);
`endif
    end

    case (state_q)
      WAIT_GAP: if (!control) state_d = IDLE;
      IDLE: if (control) begin
        {pv_d, dv_d, sv_d, tv_d, szv_d} = '0;
`ifdef EPD_FCS_CHECK_EN
        crc_ok_d = 1'b0;
`endif
        len_d    = '0;
        cnt_en_d = 1'b0;
        if (data == 8'h55) begin
          state_d   = PRE;
          pre_cnt_d = PC_W'(1);
        end else begin
          state_d   = DROP;
        end
      end
      PRE: if (control) begin
        if (data == 8'h55 && pre_cnt_q < PC_W'(PRE_LEN)) begin
          pre_cnt_d = pre_cnt_q + PC_W'(1);
        end else if (data == 8'hD5 && pre_cnt_q == PC_W'(PRE_LEN)) begin
          state_d    = DST;
          pv_d       = 1'b1;
          cnt_en_d   = 1'b1;
          fld_d      = '0;
          src_zero_d = 1'b1;
          src_ones_d = 1'b1;
`ifdef EPD_FCS_CHECK_EN
          crc_d      = '1;
`endif
        end else begin
          state_d = DROP;
        end
      end
      DST: if (control) begin
        shift_d = {shift_q[31:0], data};
        fld_d   = fld_q + 3'd1;
        if (fld_q == 3'd5) begin
          fld_d = '0;
          if (promisc || {shift_q, data} == my_addr || {shift_q, data} == '1) begin
            dv_d    = 1'b1;
            state_d = SRC;
          end else begin
            state_d = DROP;
          end
        end
      end
      SRC: if (control) begin
        src_zero_d = src_zero_q && (data == 8'h00);
        src_ones_d = src_ones_q && (data == 8'hFF);
        fld_d      = fld_q + 3'd1;
        if (fld_q == 3'd5) begin
          fld_d = '0;
          if (!src_zero_d && !src_ones_d) begin
            sv_d    = 1'b1;
            state_d = TL;
          end else begin
            state_d = DROP;
          end
        end
      end
      TL: if (control) begin
        shift_d = {shift_q[31:0], data};
        fld_d   = fld_q + 3'd1;
        if (fld_q == 3'd1) begin
          fld_d = '0;
          if (tl_val <= 16'd1500 || tl_val >= 16'h0600) begin
            tv_d    = 1'b1;
            state_d = PAYLOAD;
          end else begin
            state_d = DROP;
          end
        end
      end
      PAYLOAD: ;
      DROP: ;
      default: state_d = WAIT_GAP;
    endcase

    // First gap cycle closes the frame and updates the counters.
    if (frame_end) begin
      state_d  = IDLE;
      cnt_en_d = 1'b0;
      fd_d     = 1'b1;
      szv_d    = size_ok;
`ifdef EPD_FCS_CHECK_EN
      crc_ok_d = (crc_q == 32'hDEBB20E3);
`endif
      if (good) begin
        if (vpc_q != '1) vpc_d = vpc_q + CNT_W'(1);
      end else begin
        if (epc_q != '1) epc_d = epc_q + CNT_W'(1);
      end
    end
  end

  assign preamble_valid       = pv_q;
  assign dst_addr_valid       = dv_q;
  assign src_addr_valid       = sv_q;
  assign type_length_valid    = tv_q;
  assign packet_size_valid    = szv_q;
  assign frame_done           = fd_q;
  assign valid_packet_counter = vpc_q;
  assign error_packet_counter = epc_q;
`ifdef EPD_FCS_CHECK_EN
  assign crc_ok               = crc_ok_q;
`endif

endmodule
